// File: rtl/core_run_sequencer.sv
// Run scheduler for the RISC-V tiles: holds tiles in reset until the program image
// is loaded, then runs each selected core in ascending order until pass, fail or timeout.
module core_run_sequencer #(
   parameter int NUM_CORES  = 4,
   parameter int TIMEOUT_W  = 32,
   parameter int RESET_HOLD = 2,
   localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic                 virtual_mode,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   input  logic                 program_loaded,
   input  logic [NUM_CORES-1:0] core_pass,
   input  logic [NUM_CORES-1:0] core_fail,
   output logic [NUM_CORES-1:0] tile_reset,
   output logic [NUM_CORES-1:0] core_reset,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_W-1:0]     cur_core,
   output logic [NUM_CORES-1:0] pass_vec,
   output logic [NUM_CORES-1:0] fail_vec,
   output logic [NUM_CORES-1:0] timeout_vec,
   output logic                 all_pass
);

   localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOAD,
      REL_TILE,
      SCAN,
      PULSE,
      RUN,
      DONE
   } stateT;

   stateT                state, stateNext;
   logic [NUM_CORES-1:0] maskReg, remMask;
   logic                 vmReg;
   logic [TIMEOUT_W-1:0] limitReg, counter;
   logic [HOLD_W-1:0]    holdCnt;
   logic [IDX_W-1:0]     lowIdx;
   logic                 anyLeft;
   logic                 curPass, curFail, timeoutHit, runExit;

   // Lowest remaining core wins; scanning from the top lets the last hit be the lowest.
   always_comb begin
      lowIdx  = '0;
      anyLeft = 1'b0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (remMask[i]) begin
            lowIdx  = IDX_W'(i);
            anyLeft = 1'b1;
         end
      end
   end

   assign curPass    = core_pass[cur_core];
   assign curFail    = core_fail[cur_core];
   assign timeoutHit = (limitReg != '0) && (counter == limitReg - TIMEOUT_W'(1));
   assign runExit    = curFail | curPass | timeoutHit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE, DONE: if (start)          stateNext = WAIT_LOAD;
         WAIT_LOAD:  if (program_loaded) stateNext = REL_TILE;
         REL_TILE:                       stateNext = SCAN;
         SCAN: begin
            if (!anyLeft)   stateNext = DONE;
            else if (vmReg) stateNext = PULSE;
            else            stateNext = RUN;
         end
         PULSE:      if (holdCnt == HOLD_LAST) stateNext = RUN;
         RUN:        if (runExit)              stateNext = SCAN;
         default:                              stateNext = IDLE;
      endcase
   end

   // Every output is a register updated alongside the state transition it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tile_reset  <= '1;
         core_reset  <= '1;
         busy        <= 1'b0;
         done        <= 1'b0;
         cur_core    <= '0;
         pass_vec    <= '0;
         fail_vec    <= '0;
         timeout_vec <= '0;
         all_pass    <= 1'b0;
         maskReg     <= '0;
         remMask     <= '0;
         vmReg       <= 1'b0;
         limitReg    <= '0;
         counter     <= '0;
         holdCnt     <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  maskReg     <= core_mask;
                  remMask     <= core_mask;
                  vmReg       <= virtual_mode;
                  limitReg    <= timeout_limit;
                  pass_vec    <= '0;
                  fail_vec    <= '0;
                  timeout_vec <= '0;
                  all_pass    <= 1'b0;
                  done        <= 1'b0;
                  busy        <= 1'b1;
                  tile_reset  <= '1;
                  core_reset  <= '1;
               end
            end
            REL_TILE: tile_reset <= '0;
            SCAN: begin
               if (!anyLeft) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  all_pass <= (maskReg != '0) && (pass_vec == maskReg);
               end else begin
                  cur_core <= lowIdx;
                  if (vmReg) begin
                     tile_reset <= '1;
                     holdCnt    <= '0;
                  end else begin
                     core_reset[lowIdx] <= 1'b0;
                     counter            <= '0;
                  end
               end
            end
            PULSE: begin
               if (holdCnt == HOLD_LAST) begin
                  tile_reset           <= '0;
                  core_reset[cur_core] <= 1'b0;
                  counter              <= '0;
               end else begin
                  holdCnt <= holdCnt + HOLD_W'(1);
               end
            end
            RUN: begin
               // Fail outranks pass, and an explicit status outranks a coincident timeout.
               if (runExit) begin
                  core_reset[cur_core] <= 1'b1;
                  remMask[cur_core]    <= 1'b0;
                  if (curFail) begin
                     fail_vec[cur_core] <= 1'b1;
                  end else if (curPass) begin
                     pass_vec[cur_core] <= 1'b1;
                  end else begin
                     timeout_vec[cur_core] <= 1'b1;
                     fail_vec[cur_core]    <= 1'b1;
                  end
               end else if (counter != '1) begin
                  counter <= counter + TIMEOUT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_sequencer.sv
// Self-checking bench for core_run_sequencer: a per-core behavioural model predicts the
// release order, run lengths, reset pulses and result vectors of each run.
module tb_core_run_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  core_mask;
   logic          virtual_mode;
   logic [31:0]   timeout_limit;
   logic          program_loaded;
   logic [N-1:0]  core_pass, core_fail;
   logic [N-1:0]  tile_reset, core_reset;
   logic          busy, done, all_pass;
   logic [1:0]    cur_core;
   logic [N-1:0]  pass_vec, fail_vec, timeout_vec;

   int compared   = 0;
   int mismatched = 0;
   int runId      = 0;
   // Per-core scenario: kind 0=pass, 1=fail, 2=pass+fail, 3=silent; dly = cycles after release (0 = stale high)
   int kind[N];
   int dly[N];

   always #5 clk = ~clk;

   core_run_sequencer #(.NUM_CORES(N), .TIMEOUT_W(32), .RESET_HOLD(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .core_mask(core_mask),
      .virtual_mode(virtual_mode), .timeout_limit(timeout_limit),
      .program_loaded(program_loaded), .core_pass(core_pass), .core_fail(core_fail),
      .tile_reset(tile_reset), .core_reset(core_reset), .busy(busy), .done(done),
      .cur_core(cur_core), .pass_vec(pass_vec), .fail_vec(fail_vec),
      .timeout_vec(timeout_vec), .all_pass(all_pass)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic driveStatus(input int i);
      if (kind[i] == 0 || kind[i] == 2) core_pass[i] = 1'b1;
      if (kind[i] == 1 || kind[i] == 2) core_fail[i] = 1'b1;
   endtask

   task automatic setAll(input int k, input int d);
      for (int i = 0; i < N; i++) begin
         kind[i] = k;
         dly[i]  = d;
      end
   endtask

   // One complete run: predict outcome, drive start/load/status, observe, compare.
   task automatic applyStimulus(input logic [N-1:0] mask, input logic vm, input logic [31:0] lim,
                                input int loadDelay);
      logic [N-1:0] expPass = '0, expFail = '0, expTo = '0;
      int expLow[N], measLow[N], lowCnt[N];
      int relOrder[$], expOrder[$], pulses[$];
      int curPulse = 0, loadCyc = 0, doneCyc = 0, maxLow = 0, eff = 0, lastIdx = 0;
      bit tilesFreed = 0, finished = 0, busyDropped = 0, badTileRel = 0;
      string pfx;
      runId++;
      pfx = $sformatf("run%0d", runId);

      for (int i = 0; i < N; i++) begin
         expLow[i] = 0; measLow[i] = 0; lowCnt[i] = 0;
         if (mask[i]) begin
            expOrder.push_back(i);
            lastIdx = i;
            eff = (dly[i] < 1) ? 1 : dly[i];
            if (kind[i] == 3 || (lim != 0 && eff > int'(lim))) begin
               expTo[i] = 1'b1; expFail[i] = 1'b1; expLow[i] = int'(lim);
            end else if (kind[i] == 0) begin
               expPass[i] = 1'b1; expLow[i] = eff;
            end else begin
               expFail[i] = 1'b1; expLow[i] = eff;
            end
         end
      end

      @(negedge clk);
      start = 1'b1; core_mask = mask; virtual_mode = vm; timeout_limit = lim;
      program_loaded = (loadDelay == 0);
      core_pass = '0; core_fail = '0;
      for (int i = 0; i < N; i++)
         if (mask[i] && kind[i] != 3 && dly[i] == 0) driveStatus(i);

      for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            start = 1'b0; core_mask = 4'($urandom); virtual_mode = ~vm; timeout_limit = $urandom;
            checkOutput({pfx, "_busy_start"}, busy, 1);
            checkOutput({pfx, "_tile_held"}, tile_reset, 4'hF);
            checkOutput({pfx, "_core_held"}, core_reset, 4'hF);
            checkOutput({pfx, "_vec_clear"}, {pass_vec, fail_vec, timeout_vec, done}, 0);
         end
         if (cyc == 2) start = 1'b1;
         if (cyc == 3) start = 1'b0;
         if (cyc == loadDelay) begin
            program_loaded = 1'b1;
            loadCyc = cyc;
         end
         if ($countones(~core_reset) > maxLow) maxLow = $countones(~core_reset);
         for (int i = 0; i < N; i++) begin
            if (core_reset[i] === 1'b0) begin
               if (lowCnt[i] == 0) begin
                  relOrder.push_back(i);
                  if (tile_reset !== 4'h0) badTileRel = 1;
               end
               lowCnt[i]++;
               if (mask[i] && kind[i] != 3 && dly[i] > 0 && lowCnt[i] == dly[i]) driveStatus(i);
            end else if (lowCnt[i] > 0 && measLow[i] == 0) begin
               measLow[i] = lowCnt[i];
               core_pass[i] = 1'b0; core_fail[i] = 1'b0;
            end
            if (!mask[i]) begin
               core_pass[i] = 1'($urandom);
               core_fail[i] = 1'($urandom);
            end
         end
         if (tile_reset === 4'h0) begin
            tilesFreed = 1;
            if (curPulse > 0) begin
               pulses.push_back(curPulse);
               curPulse = 0;
            end
         end else if (tilesFreed && tile_reset === 4'hF) begin
            curPulse++;
         end
         if (done === 1'b1) begin
            finished = 1;
            doneCyc  = cyc;
         end else if (busy !== 1'b1) begin
            busyDropped = 1;
         end
      end
      core_pass = '0; core_fail = '0;

      checkOutput({pfx, "_finished"}, finished, 1);
      checkOutput({pfx, "_busy_held"}, busyDropped, 0);
      checkOutput({pfx, "_busy_end"}, busy, 0);
      checkOutput({pfx, "_pass_vec"}, pass_vec, expPass);
      checkOutput({pfx, "_fail_vec"}, fail_vec, expFail);
      checkOutput({pfx, "_timeout_vec"}, timeout_vec, expTo);
      checkOutput({pfx, "_all_pass"}, all_pass, (mask != 0 && expPass == mask));
      checkOutput({pfx, "_tile_end"}, tile_reset, 4'h0);
      checkOutput({pfx, "_core_end"}, core_reset, 4'hF);
      checkOutput({pfx, "_max_low"}, maxLow, (mask != 0) ? 1 : 0);
      checkOutput({pfx, "_tile_at_rel"}, badTileRel, 0);
      if (mask != 0) checkOutput({pfx, "_cur_core"}, cur_core, lastIdx);
      checkOutput({pfx, "_order_len"}, relOrder.size(), expOrder.size());
      for (int k = 0; k < expOrder.size() && k < relOrder.size(); k++)
         checkOutput($sformatf("%s_order%0d", pfx, k), relOrder[k], expOrder[k]);
      for (int i = 0; i < N; i++)
         if (mask[i]) checkOutput($sformatf("%s_low%0d", pfx, i), measLow[i], expLow[i]);
      checkOutput({pfx, "_pulse_cnt"}, pulses.size(), vm ? $countones(mask) : 0);
      for (int k = 0; k < pulses.size(); k++)
         checkOutput($sformatf("%s_pulse%0d", pfx, k), pulses[k], HOLD);
      if (mask == 0 && loadDelay > 0)
         checkOutput({pfx, "_empty_latency"}, doneCyc - loadCyc, 3);
   endtask

   initial begin
      logic [31:0] lim;
      rst_n = 1'b1; start = 1'b0; core_mask = '0; virtual_mode = 1'b0; timeout_limit = '0;
      program_loaded = 1'b0; core_pass = '0; core_fail = '0;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("por_tile", tile_reset, 4'hF);
      checkOutput("por_core", core_reset, 4'hF);
      checkOutput("por_flags", {busy, done, all_pass, cur_core}, 0);
      checkOutput("por_vecs", {pass_vec, fail_vec, timeout_vec}, 0);
      @(negedge clk) rst_n = 1'b1;

      setAll(0, 50);
      applyStimulus(4'b0101, 1'b0, 32'd0, 10);
      setAll(3, 5);
      applyStimulus(4'b1000, 1'b0, 32'd100, 2);
      setAll(0, 5);
      applyStimulus(4'b0011, 1'b1, 32'd0, 3);
      setAll(2, 20);
      applyStimulus(4'b0010, 1'b0, 32'd0, 1);
      applyStimulus(4'b0000, 1'b0, 32'd0, 4);
      setAll(0, 10);
      applyStimulus(4'b0001, 1'b0, 32'd10, 1);
      setAll(1, 0);
      applyStimulus(4'b1010, 1'b1, 32'd7, 0);

      for (int r = 0; r < 10; r++) begin
         lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 40));
         for (int i = 0; i < N; i++) begin
            kind[i] = int'($urandom_range(0, 3));
            if (kind[i] == 3 && lim == 0) kind[i] = 0;
            dly[i] = int'($urandom_range(0, 45));
         end
         applyStimulus(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lim,
                       int'($urandom_range(0, 6)));
      end

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      start = 1'b1; core_mask = 4'b0100; virtual_mode = 1'b0; timeout_limit = '0;
      program_loaded = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("midrun_core", core_reset, 4'b1011);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("arst_tile", tile_reset, 4'hF);
      checkOutput("arst_core", core_reset, 4'hF);
      checkOutput("arst_flags", {busy, done, all_pass}, 0);
      checkOutput("arst_vecs", {pass_vec, fail_vec, timeout_vec}, 0);
      @(negedge clk) rst_n = 1'b1;
      setAll(0, 8);
      kind[2] = 1;
      applyStimulus(4'b0110, 1'b0, 32'd0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
- Synthesizable single-thread run scheduler for the four RISC-V tiles. Holds every tile in reset, waits for program load, then releases tile resets.
- Next, releases core resets one core at a time in ascending index order over a captured mask. Each core runs until its pass, fail or timeout.
- Sits between the test-control registers (start, mask, mode, timeout) and the per-tile/per-core reset inputs. Replaces testbench force/release sequencing.

Parameters:
- NUM_CORES, 4, number of tiles sequenced.
- TIMEOUT_W, 32, width of per-core cycle timeout counter.
- RESET_HOLD, 2, cycles all tile resets are pulsed in virtual mode before each core release; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; ignored unless state is IDLE or DONE.
- core_mask  in  NUM_CORES  cores to run; captured on accepted start.
- virtual_mode  in  1  pulse all tile resets before each core release; captured on start.
- timeout_limit  in  TIMEOUT_W  max cycles per core; 0 disables timeout; captured on start.
- program_loaded  in  1  level, memory image loaded.
- core_pass  in  NUM_CORES  per-core pass status, level.
- core_fail  in  NUM_CORES  per-core fail status, level.
- tile_reset  out  NUM_CORES  active-high tile reset (caches + core).
- core_reset  out  NUM_CORES  active-high core-only reset.
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE until next accepted start.
- cur_core  out  clog2(NUM_CORES)  index of core being run/last run.
- pass_vec, fail_vec, timeout_vec  out  NUM_CORES  sticky per-core results.
- all_pass  out  1  done & mask!=0 & pass_vec==mask.

Behaviour:
- Reset values:
  - tile_reset and core_reset are all ones.
  - busy, done, cur_core, pass_vec, fail_vec, timeout_vec and all_pass are 0.
  - Counter is 0 and state is IDLE.
- All outputs are registered.
- Mid-run rst_n assertion returns immediately to the reset values, with no completion reported.
- IDLE: all resets held asserted. Accepted start moves to WAIT_LOAD next cycle and:
  - captures mask, mode and limit;
  - clears pass_vec, fail_vec, timeout_vec and done;
  - sets busy.
- Start in DONE behaves identically to start in IDLE. Start in any other state is ignored.
- WAIT_LOAD: stays while program_loaded=0. If program_loaded is already high, proceed next cycle. Moves to REL_TILE.
- REL_TILE (1 cycle): tile_reset <= 0 for all tiles; core_reset stays all ones. Moves to SCAN.
- SCAN (1 cycle):
  - Selects the lowest set bit of remaining mask into cur_core.
  - If none remain, goes to DONE. An empty mask reaches DONE with tile resets released.
  - If virtual_mode, goes to PULSE; else goes to RUN.
- PULSE:
  - tile_reset all ones for exactly RESET_HOLD cycles, then all zeros.
  - core_reset unchanged (all ones).
  - Then RUN.
- RUN:
  - core_reset[cur_core] <= 0 on entry.
  - Counter cleared on entry and increments each cycle.
  - Only core_pass/core_fail of cur_core are observed; other cores' status is ignored.
- RUN exit conditions, evaluated each cycle:
  - fail=1 (including simultaneous pass & fail) -> set fail_vec[cur].
  - Else pass=1 -> set pass_vec[cur].
  - Else timeout_limit!=0 and counter==timeout_limit-1 -> set timeout_vec[cur] and fail_vec[cur].
  - On any exit: re-assert core_reset[cur], clear cur's bit from remaining mask, go to SCAN.
- Status present at RUN entry (stale high) counts as completion on the first RUN cycle.
- Counter saturates at all ones if timeout is disabled.
- DONE: busy=0, done=1, results held, tile_reset stays 0, core_reset all ones.

Test Plan:
- Mask 4'b0101, virtual_mode 0, limit 0: program_loaded rises 10 cycles after start -> tile_reset=0; core 0 released; core_pass[0] after 50 cycles -> core_reset[0]=1; core 2 released; pass -> done=1, pass_vec=4'b0101, all_pass=1.
- Mask 4'b1000, limit 100, no status -> timeout_vec=4'b1000, fail_vec=4'b1000, core_reset[3] held low for exactly 100 cycles, all_pass=0.
- Mask 4'b0011, virtual_mode 1, RESET_HOLD=2 -> tile_reset all ones for exactly 2 cycles before each of core 0 and core 1 release.
- Core 1 running, core_pass[0] and core_fail[2] pulse -> ignored; then core_pass[1] and core_fail[1] in same cycle -> fail_vec[1]=1, pass_vec[1]=0.
- Mask 0 -> done 3 cycles after program_loaded with all_pass=0. Start while busy -> no effect.
- rst_n low mid-RUN -> all resets all ones, busy=0, done=0 asynchronously. Then a new start runs cleanly.
